// File: rtl/mdu_ctrl_pkg.sv
// Shared op codes, state encoding and payload types for the multiply/divide unit.
// Optional MADD/MSUB ops are enabled by defining MDU_MADD_EN.
package mdu_ctrl_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] MD_NONE  = 4'd0;
   localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
   localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
   localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
   localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
   localparam logic [OP_W-1:0] MD_MTHI  = 4'd5;
   localparam logic [OP_W-1:0] MD_MTLO  = 4'd6;
   localparam logic [OP_W-1:0] MD_MADD  = 4'd7;
   localparam logic [OP_W-1:0] MD_MSUB  = 4'd8;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
   } md_pair_t;

   // Ops that occupy the unit for a multi-cycle latency before committing HI/LO.
   function automatic logic is_long_op(input logic [OP_W-1:0] op);
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_long_op = 1'b1;
`ifdef MDU_MADD_EN
         MD_MADD, MD_MSUB:                   is_long_op = 1'b1;
`endif
         default:                            is_long_op = 1'b0;
      endcase
   endfunction

   function automatic logic is_div_op(input logic [OP_W-1:0] op);
      is_div_op = (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {HI,LO} result.
// MADD/MSUB accumulate onto hi_in/lo_in when MDU_MADD_EN is defined.
module mdu_arith
   import mdu_ctrl_pkg::*;
(
   input  logic [OP_W-1:0] op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [XLEN-1:0] hi_in,
   input  logic [XLEN-1:0] lo_in,
   output md_pair_t        res,
   output logic            div0
);

   logic signed [2*XLEN-1:0] s_prod;
   logic        [2*XLEN-1:0] u_prod;
   logic signed [XLEN-1:0]   s_quo;
   logic signed [XLEN-1:0]   s_rem;
   logic        [XLEN-1:0]   u_quo;
   logic        [XLEN-1:0]   u_rem;
   logic                     b_zero;
   logic                     s_ovf;

   always_comb begin
      s_prod = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
      u_prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
      b_zero = (b == '0);
      s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      s_quo  = '0;
      s_rem  = '0;
      u_quo  = '0;
      u_rem  = '0;
      // Most-negative / -1 wraps to itself with zero remainder instead of trapping.
      if (!b_zero) begin
         u_quo = a / b;
         u_rem = a % b;
         if (s_ovf) begin
            s_quo = $signed(a);
         end else begin
            s_quo = $signed(a) / $signed(b);
            s_rem = $signed(a) % $signed(b);
         end
      end
   end

   always_comb begin
      res  = {hi_in, lo_in};
      div0 = is_div_op(op) && b_zero;
      case (op)
         MD_MULT:  res = md_pair_t'(s_prod);
         MD_MULTU: res = md_pair_t'(u_prod);
         MD_DIV:   if (!b_zero) res = md_pair_t'({s_rem, s_quo});
         MD_DIVU:  if (!b_zero) res = md_pair_t'({u_rem, u_quo});
`ifdef MDU_MADD_EN
         MD_MADD:  res = md_pair_t'({hi_in, lo_in} + s_prod);
         MD_MSUB:  res = md_pair_t'({hi_in, lo_in} - s_prod);
`endif
         default:  res = {hi_in, lo_in};
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: latches a pending result, holds it for the op
// latency, then commits to HI/LO. MDU_MADD_EN enables the MADD/MSUB ops.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned CNT_W    = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [3:0]      md_op,
   input  logic [31:0]     a,
   input  logic [31:0]     b,
   input  logic            d_use_md,
   output logic [31:0]     hi,
   output logic [31:0]     lo,
   output logic            busy,
   output logic            md_stall
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  hi_q, hi_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   md_pair_t         pend_q, pend_d;
   logic             div0_q, div0_d;
   logic             busy_q, busy_d;

   md_pair_t         arith_res;
   logic             arith_div0;
   logic             long_start;
   logic             last_cnt;

   mdu_arith u_arith (
      .op    (md_op),
      .a     (a),
      .b     (b),
      .hi_in (hi_q),
      .lo_in (lo_q),
      .res   (arith_res),
      .div0  (arith_div0)
   );

   assign long_start = start && is_long_op(md_op);
   assign last_cnt   = (cnt_q == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset) state_q <= MD_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (long_start) state_d = MD_RUN;
         MD_RUN:  if (last_cnt)   state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   // Datapath next-state: accept in IDLE, count down and commit in RUN.
   always_comb begin
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      pend_d = pend_q;
      div0_d = div0_q;
      case (state_q)
         MD_IDLE: begin
            if (long_start) begin
               pend_d = arith_res;
               div0_d = arith_div0;
               cnt_d  = is_div_op(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            end else if (start && (md_op == MD_MTHI)) begin
               hi_d = a;
            end else if (start && (md_op == MD_MTLO)) begin
               lo_d = a;
            end
         end
         MD_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (last_cnt && !div0_q) begin
               hi_d = pend_q.hi;
               lo_d = pend_q.lo;
            end
         end
         default: cnt_d = '0;
      endcase
      busy_d = (state_d == MD_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         pend_q <= '0;
         div0_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         pend_q <= pend_d;
         div0_q <= div0_d;
         busy_q <= busy_d;
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = busy_q;
   // Stall must react in the same cycle a long op is issued, so it stays combinational.
   assign md_stall = d_use_md && (busy_q || long_start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random ops against a
// cycle-level behavioural model. Honours MDU_MADD_EN like the design.
module tb_mdu_ctrl;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_use_md;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        md_stall;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_hi, m_lo;
   logic [63:0] m_pend;
   bit          m_div0;
   int          m_left;

   mdu_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .md_op    (md_op),
      .a        (a),
      .b        (b),
      .d_use_md (d_use_md),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .md_stall (md_stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_long(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op >= 4'd1 && op <= 4'd4) || op == 4'd7 || op == 4'd8;
`else
      return (op >= 4'd1 && op <= 4'd4);
`endif
   endfunction

   // One clock edge of the architectural model.
   task automatic model_edge(input bit rst, input bit st, input logic [3:0] op,
                             input logic [31:0] aa, input logic [31:0] bb);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      sa = longint'($signed(aa));
      sb = longint'($signed(bb));
      ua = {32'd0, aa};
      ub = {32'd0, bb};
      if (rst) begin
         m_hi = '0; m_lo = '0; m_left = 0; m_div0 = 0; m_pend = '0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && !m_div0) {m_hi, m_lo} = m_pend;
      end else if (st) begin
         m_div0 = 0;
         case (op)
            4'd1: begin m_pend = 64'(sa * sb); m_left = MULT_LAT; end
            4'd2: begin m_pend = 64'(ua * ub); m_left = MULT_LAT; end
            4'd3: begin
               m_left = DIV_LAT;
               if (bb == 0) m_div0 = 1;
               else begin q = sa / sb; r = sa % sb; m_pend = {32'(r), 32'(q)}; end
            end
            4'd4: begin
               m_left = DIV_LAT;
               if (bb == 0) m_div0 = 1;
               else m_pend = {32'(ua % ub), 32'(ua / ub)};
            end
            4'd5: m_hi = aa;
            4'd6: m_lo = aa;
`ifdef MDU_MADD_EN
            4'd7: begin m_pend = {m_hi, m_lo} + 64'(sa * sb); m_left = MULT_LAT; end
            4'd8: begin m_pend = {m_hi, m_lo} - 64'(sa * sb); m_left = MULT_LAT; end
`endif
            default: ;
         endcase
      end
   endtask

   task automatic step(input bit rst, input bit st, input logic [3:0] op,
                       input logic [31:0] aa, input logic [31:0] bb, input bit du);
      @(negedge clk);
      reset = rst; start = st; md_op = op; a = aa; b = bb; d_use_md = du;
      #1;
      check("md_stall", 64'(md_stall), 64'(du && (m_left > 0 || (st && model_long(op)))));
      @(posedge clk);
      model_edge(rst, st, op, aa, bb);
      #1;
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("busy", 64'(busy), 64'(m_left > 0));
   endtask

   task automatic idle(input int n, input bit du);
      for (int i = 0; i < n; i++) step(0, 0, 4'd0, 32'd0, 32'd0, du);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1; start = 0; md_op = 0; a = 0; b = 0; d_use_md = 0;
      m_hi = '0; m_lo = '0; m_left = 0; m_div0 = 0; m_pend = '0;

      step(1, 0, 4'd0, 32'd0, 32'd0, 0);
      step(1, 1, 4'd1, 32'd5, 32'd5, 0);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);

      // MULT -2*3 with D-stage user present: stall on start cycle and all busy cycles.
      step(0, 1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1);
      check("mult_stall_busy", 64'(busy), 64'd1);
      idle(4, 1);
      check("mult_not_yet", 64'(lo), 64'd0);
      idle(1, 1);
      check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      check("mult_lo", 64'(lo), 64'hFFFF_FFFA);
      check("mult_done", 64'(busy), 64'd0);
      idle(1, 1);
      step(0, 1, 4'd2, 32'd6, 32'd7, 0);
      idle(MULT_LAT, 0);

      // Divide by zero leaves MTHI/MTLO values in place.
      step(0, 1, 4'd5, 32'h1234, 32'd0, 0);
      step(0, 1, 4'd6, 32'h5678, 32'd0, 0);
      step(0, 1, 4'd3, 32'd99, 32'd0, 0);
      idle(DIV_LAT, 0);
      check("div0_hi", 64'(hi), 64'h1234);
      check("div0_lo", 64'(lo), 64'h5678);

      step(0, 1, 4'd4, 32'd100, 32'd7, 0);
      idle(DIV_LAT, 0);
      check("divu_lo", 64'(lo), 64'd14);
      check("divu_hi", 64'(hi), 64'd2);

      step(0, 1, 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
      idle(DIV_LAT, 0);
      check("div_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_hi", 64'(hi), 64'hFFFF_FFFF);

      step(0, 1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      idle(DIV_LAT, 0);
      check("div_ovf_lo", 64'(lo), 64'h8000_0000);
      check("div_ovf_hi", 64'(hi), 64'd0);

      // Reset in the middle of a DIV aborts it.
      step(0, 1, 4'd4, 32'd100, 32'd7, 0);
      idle(2, 0);
      step(1, 0, 4'd0, 32'd0, 32'd0, 0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      idle(DIV_LAT + 2, 0);
      check("abort_no_commit", 64'(lo), 64'd0);

      // Start while busy is ignored.
      step(0, 1, 4'd1, 32'd9, 32'd9, 0);
      step(0, 1, 4'd4, 32'd50, 32'd5, 0);
      step(0, 1, 4'd5, 32'hDEAD, 32'd0, 0);
      idle(MULT_LAT, 0);
      check("busy_ignore_lo", 64'(lo), 64'd81);
      check("busy_ignore_hi", 64'(hi), 64'd0);

      // Op 7: MADD when enabled, otherwise a no-op.
      step(0, 1, 4'd5, 32'd0, 32'd0, 0);
      step(0, 1, 4'd6, 32'd10, 32'd0, 0);
      step(0, 1, 4'd7, 32'd3, 32'd4, 1);
`ifdef MDU_MADD_EN
      check("madd_busy", 64'(busy), 64'd1);
      idle(MULT_LAT, 0);
      check("madd_lo", 64'(lo), 64'd22);
`else
      check("op7_busy", 64'(busy), 64'd0);
      idle(MULT_LAT, 0);
      check("op7_lo", 64'(lo), 64'd10);
`endif

      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
              4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
              $urandom_range(0, 1) == 1);
      end
      idle(DIV_LAT + 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
